// File: rtl/bm_sigma_solver_if.sv
// Handshake and result bundle between the RS syndrome stage, the sigma solver and Chien search.
// The master side drives start/syn_in and the slave side returns the locator result.
interface bm_sigma_solver_if #(
  parameter int unsigned T = 3,
  parameter int unsigned M = 8
);
  logic               start;
  logic [2*T*M-1:0]   syn_in;
  logic               busy;
  logic               done;
  logic [(T+1)*M-1:0] sigma_out;
  logic [3:0]         deg;
  logic               fail;

  modport master (
    output start, syn_in,
    input  busy, done, sigma_out, deg, fail
  );

  modport slave (
    input  start, syn_in,
    output busy, done, sigma_out, deg, fail
  );
endinterface

// File: rtl/bm_sigma_solver.sv
// Inversionless Berlekamp-Massey error-locator solver, one iteration per clock.
// Define BM_SIGMA_NORMALIZE_EN to add an 8-cycle NORM phase that makes sigma_out monic.
module bm_sigma_solver #(
  parameter int unsigned T         = 3,
  parameter int unsigned M         = 8,
  parameter logic [M:0]  PRIM_POLY = 9'h11D
) (
  input logic              clk,
  input logic              rst_n,
  bm_sigma_solver_if.slave bus
);

  localparam logic [3:0] TL     = 4'(T);
  localparam logic [3:0] RLast  = 4'(2 * T - 1);
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StIter = 2'd1;
  localparam logic [1:0] StDone = 2'd3;
`ifdef BM_SIGMA_NORMALIZE_EN
  localparam logic [1:0] StNorm = 2'd2;
`endif

  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] acc;
    logic [M-1:0] sh;
    acc = '0;
    sh  = a;
    for (int k = 0; k < int'(M); k++) begin
      if (b[k]) acc ^= sh;
      sh = sh[M-1] ? ((sh << 1) ^ PRIM_POLY[M-1:0]) : (sh << 1);
    end
    return acc;
  endfunction

  logic [1:0]         r_state;
  logic [M-1:0]       r_syn   [2*T];
  logic [M-1:0]       r_sigma [T+1];
  logic [M-1:0]       r_b     [T+1];
  logic [M-1:0]       r_gamma;
  logic [3:0]         r_l;
  logic [3:0]         r_r;
  logic               r_busy;
  logic               r_done;
  logic               r_fail;
  logic [3:0]         r_deg;
  logic [(T+1)*M-1:0] r_sigma_out;

  logic [M-1:0]       w_delta;
  logic [M-1:0]       w_sigma_nxt [T+1];
  logic               w_upd;
  logic [(T+1)*M-1:0] w_sigma_flat;

`ifdef BM_SIGMA_NORMALIZE_EN
  logic [2:0]   r_cnt;
  logic [M-1:0] r_p;
  logic [M-1:0] w_sq;
  assign w_sq = gf_mul(r_p, r_p);
`endif

  // Discrepancy: terms with syndrome index below 1 contribute nothing.
  always_comb begin
    w_delta = '0;
    for (int i = 0; i <= int'(T); i++) begin
      if (int'(r_r) >= i) w_delta ^= gf_mul(r_sigma[i], r_syn[int'(r_r) - i]);
    end
  end

  // gamma*sigma + delta*x*B; B's top coefficient falls off the x^T end.
  always_comb begin
    w_sigma_nxt[0] = gf_mul(r_gamma, r_sigma[0]);
    for (int i = 1; i <= int'(T); i++) begin
      w_sigma_nxt[i] = gf_mul(r_gamma, r_sigma[i]) ^ gf_mul(w_delta, r_b[i-1]);
    end
  end

  assign w_upd = (w_delta != '0) && ({r_l, 1'b0} <= {1'b0, r_r});

  always_comb begin
    w_sigma_flat = '0;
    for (int i = 0; i <= int'(T); i++) w_sigma_flat[i*M +: M] = r_sigma[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      for (int j = 0; j < 2 * int'(T); j++) r_syn[j] <= '0;
      for (int i = 0; i <= int'(T); i++) begin
        r_sigma[i] <= (i == 0) ? M'(1) : '0;
        r_b[i]     <= (i == 0) ? M'(1) : '0;
      end
      r_gamma     <= M'(1);
      r_l         <= '0;
      r_r         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_deg       <= '0;
      r_sigma_out <= {{(T*M){1'b0}}, M'(1)};
`ifdef BM_SIGMA_NORMALIZE_EN
      r_cnt       <= '0;
      r_p         <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (bus.start) begin
            for (int j = 0; j < 2 * int'(T); j++) r_syn[j] <= bus.syn_in[j*M +: M];
            for (int i = 0; i <= int'(T); i++) begin
              r_sigma[i] <= (i == 0) ? M'(1) : '0;
              r_b[i]     <= (i == 0) ? M'(1) : '0;
            end
            r_gamma <= M'(1);
            r_l     <= '0;
            r_r     <= '0;
            r_busy  <= 1'b1;
            r_state <= StIter;
          end
        end
        StIter: begin
          for (int i = 0; i <= int'(T); i++) r_sigma[i] <= w_sigma_nxt[i];
          if (w_upd) begin
            for (int i = 0; i <= int'(T); i++) r_b[i] <= r_sigma[i];
            r_l     <= r_r + 4'd1 - r_l;
            r_gamma <= w_delta;
          end else begin
            r_b[0] <= '0;
            for (int i = 1; i <= int'(T); i++) r_b[i] <= r_b[i-1];
          end
          r_r <= r_r + 4'd1;
          if (r_r == RLast) begin
`ifdef BM_SIGMA_NORMALIZE_EN
            r_cnt   <= '0;
            r_state <= StNorm;
`else
            r_busy  <= 1'b0;
            r_state <= StDone;
`endif
          end
        end
`ifdef BM_SIGMA_NORMALIZE_EN
        // p walks s^1, s^3, ..., s^127; the last step squares it to s^254 = 1/s.
        StNorm: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd0) begin
            r_p <= r_sigma[0];
          end else if (r_cnt != 3'd7) begin
            r_p <= gf_mul(w_sq, r_sigma[0]);
          end else begin
            for (int i = 0; i <= int'(T); i++) r_sigma[i] <= gf_mul(r_sigma[i], w_sq);
            r_busy  <= 1'b0;
            r_state <= StDone;
          end
        end
`endif
        StDone: begin
          r_done      <= 1'b1;
          r_sigma_out <= w_sigma_flat;
          r_deg       <= r_l;
          r_fail      <= (r_l > TL);
          r_state     <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.sigma_out = r_sigma_out;
  assign bus.deg       = r_deg;
  assign bus.fail      = r_fail;

endmodule

// File: tb/tb_bm_sigma_solver.sv
// Directed bench for bm_sigma_solver (T=3, GF(2^8)/0x11D) with hand-derived locators.
// Honours BM_SIGMA_NORMALIZE_EN for latency and monic expectations.
module tb_bm_sigma_solver;

`ifdef BM_SIGMA_NORMALIZE_EN
  localparam int          Lat    = 15;
  localparam logic [31:0] ExpA1  = 32'h0000_0201;
  localparam logic [31:0] ExpTwo = 32'h0002_0301;
`else
  localparam int          Lat    = 7;
  localparam logic [31:0] ExpA1  = 32'h0000_4020;
  localparam logic [31:0] ExpTwo = 32'h00DD_3DE0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [31:0] g_prev;
  int   lat;
  int   busy_n;
  int   extra;
  logic [7:0] sig [4];

  bm_sigma_solver_if #(.T(3), .M(8)) bus ();

  bm_sigma_solver #(.T(3), .M(8), .PRIM_POLY(9'h11D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] tb_gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    logic [14:0] poly;
    p    = '0;
    poly = 15'(9'h11D);
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 15'(a) << i;
    for (int i = 14; i >= 8; i--) if (p[i]) p ^= poly << (i - 8);
    return p[7:0];
  endfunction

  function automatic logic [7:0] tb_eval(input logic [31:0] s, input logic [7:0] x);
    logic [7:0] acc;
    acc = s[31:24];
    for (int i = 2; i >= 0; i--) acc = tb_gf_mul(acc, x) ^ s[i*8 +: 8];
    return acc;
  endfunction

  // Launch one job; optional start re-pulses at cycles 2, 4 and in the DONE cycle.
  task automatic run_job(input logic [47:0] syn, input bit repulse,
                         output int lat_o, output int busy_o);
    lat_o  = -1;
    busy_o = 0;
    @(negedge clk);
    bus.syn_in = syn;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.syn_in = '0;
    if (bus.busy) busy_o++;
    for (int k = 1; k <= 40 && lat_o < 0; k++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (k == 3) check_eq("hold_prev", bus.sigma_out, g_prev);
      if (bus.done) lat_o = k;
      else if (bus.busy) busy_o++;
      if (repulse && (k == 2 || k == 4 || k == Lat - 1)) begin
        bus.syn_in = 48'h0101_0101_0101;
        bus.start  = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_eq("done_pulse", bus.done, 1'b0);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.syn_in = '0;
    g_prev     = 32'h0000_0001;
    repeat (3) @(negedge clk);
    check_eq("rst_sigma", bus.sigma_out, 32'h0000_0001);
    check_eq("rst_deg",   bus.deg,  4'd0);
    check_eq("rst_fail",  bus.fail, 1'b0);
    check_eq("rst_busy",  bus.busy, 1'b0);
    check_eq("rst_done",  bus.done, 1'b0);
    rst_n = 1'b1;

    // All-zero syndromes
    run_job(48'h0, 1'b0, lat, busy_n);
    check_eq("zero_lat",   lat, Lat);
    check_eq("zero_busy",  busy_n, Lat - 1);
    check_eq("zero_sigma", bus.sigma_out, 32'h0000_0001);
    check_eq("zero_deg",   bus.deg, 4'd0);
    check_eq("zero_fail",  bus.fail, 1'b0);
    g_prev = 32'h0000_0001;

    // Single error at alpha^0
    run_job(48'h0101_0101_0101, 1'b0, lat, busy_n);
    check_eq("one_lat",   lat, Lat);
    check_eq("one_sigma", bus.sigma_out, 32'h0000_0101);
    check_eq("one_deg",   bus.deg, 4'd1);
    check_eq("one_fail",  bus.fail, 1'b0);
    g_prev = 32'h0000_0101;

    // Single error at alpha^1
    run_job(48'h4020_1008_0402, 1'b0, lat, busy_n);
    check_eq("a1_lat",   lat, Lat);
    check_eq("a1_sigma", bus.sigma_out, ExpA1);
    check_eq("a1_deg",   bus.deg, 4'd1);
    g_prev = ExpA1;

    // Two errors at alpha^0, alpha^1 with start re-pulsed mid-job and in DONE
    run_job(48'h4121_1109_0503, 1'b1, lat, busy_n);
    check_eq("rep_lat",   lat, Lat);
    check_eq("rep_sigma", bus.sigma_out, ExpTwo);
    check_eq("rep_deg",   bus.deg, 4'd2);
    check_eq("rep_fail",  bus.fail, 1'b0);
    extra = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) extra++;
    end
    check_eq("rep_no_extra_done", extra, 0);
    g_prev = ExpTwo;

    // Only S6 nonzero: L grows to 6, beyond T
    run_job(48'h0100_0000_0000, 1'b0, lat, busy_n);
    check_eq("unc_sigma", bus.sigma_out, 32'h0000_0001);
    check_eq("unc_deg",   bus.deg, 4'd6);
    check_eq("unc_fail",  bus.fail, 1'b1);

    // Asynchronous reset in the middle of ITER
    @(negedge clk);
    bus.syn_in = 48'h0101_0101_0101;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_sigma", bus.sigma_out, 32'h0000_0001);
    check_eq("arst_deg",   bus.deg,  4'd0);
    check_eq("arst_fail",  bus.fail, 1'b0);
    check_eq("arst_busy",  bus.busy, 1'b0);
    check_eq("arst_done",  bus.done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    g_prev = 32'h0000_0001;
    run_job(48'h4121_1109_0503, 1'b0, lat, busy_n);
    check_eq("post_lat",   lat, Lat);
    check_eq("post_sigma", bus.sigma_out, ExpTwo);
    check_eq("post_deg",   bus.deg, 4'd2);
    g_prev = ExpTwo;

    // Three errors at alpha^0, alpha^1, alpha^2 (monic locator 1 + 07x + 0Ex^2 + 08x^3)
    run_job(48'h8C55_0C49_1507, 1'b0, lat, busy_n);
    for (int i = 0; i < 4; i++) sig[i] = bus.sigma_out[i*8 +: 8];
    check_eq("tri_lat",     lat, Lat);
    check_eq("tri_deg",     bus.deg, 4'd3);
    check_eq("tri_fail",    bus.fail, 1'b0);
    check_eq("tri_s0_nz",   sig[0] != 8'h00, 1'b1);
    check_eq("tri_root_a0", tb_eval(bus.sigma_out, 8'h01), 8'h00);
    check_eq("tri_root_a1", tb_eval(bus.sigma_out, 8'h8E), 8'h00);
    check_eq("tri_root_a2", tb_eval(bus.sigma_out, 8'h47), 8'h00);
    check_eq("tri_nonroot", tb_eval(bus.sigma_out, 8'hAD) != 8'h00, 1'b1);
`ifdef BM_SIGMA_NORMALIZE_EN
    check_eq("tri_monic", bus.sigma_out, 32'h080E_0701);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bm_sigma_solver.md
Name: bm_sigma_solver

Overview:
- Parametrised, iterative error-locator solver for the Reed-Solomon decoder: syndromes S1..S2T in, sigma(x) out.
- Replaces the closed-form, fixed 3-error determinant/equation solve with an inversionless Berlekamp-Massey (iBM) engine.
- Handles any error count up to T, one iteration per clock, with no GF inverters in the datapath.
- Sits between the syndrome calculator and the Chien search.

Parameters:
- T, 3, max correctable errors; 2T syndromes consumed; 1 <= T <= 7.
- M, 8, symbol width (GF(2^M)); only 8 is required and verified.
- PRIM_POLY, 9'h11D, field primitive polynomial for all GF multipliers.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only in IDLE.
- syn_in  in  2T*M  syndromes, S1 in bits [M-1:0], Sj in bits [j*M-1:(j-1)*M].
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse when results are valid.
- sigma_out  out  (T+1)*M  sigma_0 in the LSBs up to sigma_T.
- deg  out  4  final register L (claimed error count).
- fail  out  1  uncorrectable (L > T), valid with done.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, fail=0, deg=0; sigma_out = 0x01 in coefficient 0, all other coefficients 0. Internal registers cleared the same way.
- States: IDLE, ITER, optional NORM, DONE.
- IDLE: on start=1, register syn_in and initialise: sigma=1, B=1, L=0, gamma=1, r=0. Go to ITER.
- ITER: one iteration per cycle, r = 0..2T-1.
  - delta = XOR over i=0..T of sigma_i * S(r+1-i), where S(j)=0 for j<1.
  - sigma' = gamma*sigma XOR delta*(x*B). The x*B shift drops the coefficient beyond x^T.
  - If delta != 0 and 2L <= r: B=sigma (old), L=r+1-L, gamma=delta.
  - Otherwise: B=x*B; L and gamma unchanged.
  - After r=2T-1: go to NORM if enabled, else DONE.
- DONE: for one cycle drive sigma_out=sigma, deg=L, fail=(L>T), done=1, busy=0; then return to IDLE.
- Output holding: sigma_out, deg and fail hold their values until the next done. They are not cleared on a new start.
- Latency: done is high in the cycle after the (2T+1)th rising edge following the accepting edge, i.e. 2T+1 cycles of busy/iteration. Example: T=3 gives done 7 cycles after the start edge. NORM adds 8 cycles.
- start while busy: ignored, with no effect on the in-flight job. start during the DONE cycle is also ignored.
- Without normalisation, sigma is a nonzero scalar multiple of the monic locator. sigma_0 = product of the gammas, which is never 0. Roots are identical to the monic form.
- All-zero syndromes: every delta=0, so sigma=1, deg=0, fail=0.
- Arithmetic: GF(2^M) addition is XOR; multiplication is combinational, reduced by PRIM_POLY.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: BM_SIGMA_NORMALIZE_EN.
- Defined: the NORM state computes inv = sigma_0^254, then multiplies every coefficient by inv, so sigma_out is monic (sigma_0 = 0x01).
  - inv is computed by 7 square-and-multiply steps: p=s, then p=p^2*s six times, then p=p^2.
  - The coefficient multiply takes 1 cycle; total NORM = 8 cycles.
- Undefined: NORM state and its logic are absent; output is the scaled sigma.

Test Plan:
- Zero syndromes (T=3), start pulse:
  - done exactly 7 cycles later.
  - sigma_out coefficients {01,00,00,00}, deg=0, fail=0, busy high for 6 cycles.
- S1..S6 = 01 (single error, value 1 at location alpha^0):
  - sigma {01,01,00,00}, deg=1, fail=0, with or without normalisation.
- S1..S6 = 02,04,08,10,20,40 (error at alpha^1):
  - unnormalised: sigma {20,40,00,00}, deg=1.
  - with BM_SIGMA_NORMALIZE_EN: sigma {01,02,00,00}, done 15 cycles after start.
- Random 1..3 errors vs a software iBM model, 1000 vectors:
  - sigma matches up to scalar; Chien roots equal the injected locations; deg equals the error count.
- start re-pulsed on cycles 2 and 4 of a job:
  - a single done at the original latency, results from the first syn_in.
- rst_n asserted low during ITER:
  - outputs return to reset values immediately (asynchronously).
  - the next start after release completes normally with correct results.
